// File: rtl/float_to_double.sv
// IEEE 754 single-to-double widening converter with a start/done handshake.
// Subnormal singles are normalised one bit per cycle; all other classes take two cycles.
module float_to_double (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] float,
    output logic [63:0] double,
    output logic        done,
    output logic        busy,
    output logic        nan_exception
);

    typedef enum logic [1:0] {IDLE, CLASSIFY, NORMALIZE} state_t;

    state_t      state, state_next;
    logic        sign, sign_next;
    logic [7:0]  exp_f, exp_f_next;
    logic [22:0] man, man_next;
    logic [22:0] w, w_next;
    logic [4:0]  k, k_next;
    logic [63:0] double_next;
    logic        done_next;
    logic        nan_next;

    // Rebias 127 -> 1023; an 8-bit exponent plus 896 always fits in 11 bits.
    function automatic logic [63:0] pack_normal(input logic s, input logic [7:0] e,
                                                input logic [22:0] m);
        return {s, {3'b000, e} + 11'd896, m, 29'b0};
    endfunction

    function automatic logic [63:0] pack_nan(input logic s, input logic [22:0] m);
        return {s, 11'h7FF, 1'b1, m[21:0], 29'b0};
    endfunction

    // Called on the final shift: w[22] is the hidden one about to leave the field.
    function automatic logic [63:0] pack_subnormal(input logic s, input logic [4:0] cnt,
                                                   input logic [22:0] wr);
        return {s, 11'd896 - {6'b000000, cnt}, wr[21:0], 1'b0, 29'b0};
    endfunction

    always_comb begin
        state_next  = state;
        sign_next   = sign;
        exp_f_next  = exp_f;
        man_next    = man;
        w_next      = w;
        k_next      = k;
        double_next = double;
        done_next   = 1'b0;
        nan_next    = nan_exception;

        case (state)
            IDLE: begin
                if (start) begin
                    sign_next  = float[31];
                    exp_f_next = float[30:23];
                    man_next   = float[22:0];
                    w_next     = float[22:0];
                    k_next     = 5'd0;
                    nan_next   = 1'b0;
                    state_next = CLASSIFY;
                end
            end

            CLASSIFY: begin
                state_next = IDLE;
                done_next  = 1'b1;
                if (exp_f == 8'd0 && man == 23'd0) begin
                    double_next = {sign, 63'b0};
                end else if (exp_f == 8'hFF && man == 23'd0) begin
                    double_next = {sign, 11'h7FF, 52'b0};
                end else if (exp_f == 8'hFF) begin
                    double_next = pack_nan(sign, man);
                    nan_next    = ~man[22];
                end else if (exp_f == 8'd0) begin
                    state_next = NORMALIZE;
                    done_next  = 1'b0;
                end else begin
                    double_next = pack_normal(sign, exp_f, man);
                end
            end

            NORMALIZE: begin
                w_next = w << 1;
                k_next = k + 5'd1;
                if (w[22]) begin
                    double_next = pack_subnormal(sign, k, w);
                    done_next   = 1'b1;
                    state_next  = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sign          <= 1'b0;
            exp_f         <= 8'd0;
            man           <= 23'd0;
            w             <= 23'd0;
            k             <= 5'd0;
            double        <= 64'd0;
            done          <= 1'b0;
            nan_exception <= 1'b0;
        end else begin
            state         <= state_next;
            sign          <= sign_next;
            exp_f         <= exp_f_next;
            man           <= man_next;
            w             <= w_next;
            k             <= k_next;
            double        <= double_next;
            done          <= done_next;
            nan_exception <= nan_next;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_float_to_double.sv
// Self-checking bench for float_to_double: directed cases, handshake corners,
// reset abort and randomized operands against an arithmetic reference model.
module tb_float_to_double;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] f_in = 32'd0;
    logic [63:0] d_out;
    logic        done;
    logic        busy;
    logic        nan_exception;

    int checks = 0;
    int errors = 0;

    float_to_double dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .float         (f_in),
        .double        (d_out),
        .done          (done),
        .busy          (busy),
        .nan_exception (nan_exception)
    );

    always #5 clk = ~clk;

    // Reference: decode the single as a value and re-encode it as a double.
    function automatic void model(input logic [31:0] f, output logic [63:0] d,
                                  output logic nan, output int lat);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [22:0] mm;
        int          p;
        int          n;
        s = f[31]; e = f[30:23]; m = f[22:0];
        nan = 1'b0;
        lat = 2;
        if (e == 8'd255) begin
            if (m == 23'd0) d = {s, 11'h7FF, 52'b0};
            else begin
                d   = {s, 11'h7FF, 1'b1, m[21:0], 29'b0};
                nan = (m[22] == 1'b0);
            end
        end else if (e == 8'd0) begin
            if (m == 23'd0) d = {s, 63'b0};
            else begin
                // value = m * 2^-149; leading one at bit p gives unbiased exponent p-149
                p = 0;
                for (int i = 0; i < 23; i++) if (m[i]) p = i;
                n  = 23 - p;
                mm = 23'(m << n);
                d  = {s, 11'(p - 149 + 1023), mm, 29'b0};
                lat = 2 + n;
            end
        end else begin
            d = {s, 11'(int'(e) - 127 + 1023), m, 29'b0};
        end
    endfunction

    // Drive one request and wait for done; cyc counts edges from the accepting edge (=1).
    task automatic do_conv(input logic [31:0] f, output logic [63:0] d, output logic nan,
                           output int cyc, output int bcyc, output bit to);
        @(negedge clk);
        f_in  = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc  = 1;
        bcyc = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) bcyc++;
        end
        to  = !done;
        d   = d_out;
        nan = nan_exception;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL reset_double got=%h exp=0", d_out); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (nan_exception !== 1'b0) begin errors++; $display("FAIL reset_nan got=%b exp=0", nan_exception); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] fin  [10] = '{32'h3F800000, 32'h7F7FFFFF, 32'h00000000, 32'h80000000,
                                   32'hFF800000, 32'h7F800001, 32'h7FC00000, 32'h00000001,
                                   32'h007FFFFF, 32'h80400000};
        logic [63:0] dexp [10] = '{64'h3FF0000000000000, 64'h47EFFFFFE0000000, 64'h0,
                                   64'h8000000000000000, 64'hFFF0000000000000,
                                   64'h7FF8000020000000, 64'h7FF8000000000000,
                                   64'h36A0000000000000, 64'h380FFFFFC0000000,
                                   64'hB800000000000000};
        logic        nexp [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        int          lexp [10] = '{2, 2, 2, 2, 2, 2, 2, 25, 3, 3};
        logic [63:0] d;
        logic        nan;
        int          cyc, bcyc;
        bit          to;
        for (int i = 0; i < 10; i++) begin
            do_conv(fin[i], d, nan, cyc, bcyc, to);
            checks++; if (to) begin errors++; $display("FAIL dir_timeout in=%h no done within 40 cycles", fin[i]); end
            checks++; if (d !== dexp[i]) begin errors++; $display("FAIL dir_double in=%h got=%h exp=%h", fin[i], d, dexp[i]); end
            checks++; if (nan !== nexp[i]) begin errors++; $display("FAIL dir_nan in=%h got=%b exp=%b", fin[i], nan, nexp[i]); end
            checks++; if (cyc != lexp[i]) begin errors++; $display("FAIL dir_latency in=%h got=%0d exp=%0d", fin[i], cyc, lexp[i]); end
            checks++; if (bcyc != lexp[i] - 1) begin errors++; $display("FAIL dir_busy in=%h got=%0d exp=%0d", fin[i], bcyc, lexp[i] - 1); end
            @(posedge clk);
            #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir_done_pulse in=%h got=%b exp=0", fin[i], done); end
        end
    endtask

    task automatic test_nan_clear();
        logic [63:0] d;
        logic        nan;
        int          cyc, bcyc;
        bit          to;
        do_conv(32'hFF800002, d, nan, cyc, bcyc, to);
        checks++; if (nan !== 1'b1) begin errors++; $display("FAIL snan_flag got=%b exp=1", nan); end
        // Flag must drop on the accepting edge of the next request.
        @(negedge clk);
        f_in  = 32'h3F800000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (nan_exception !== 1'b0) begin errors++; $display("FAIL nan_clear_on_accept got=%b exp=0", nan_exception); end
        @(posedge clk);
        #1;
        checks++; if (d_out !== 64'h3FF0000000000000) begin errors++; $display("FAIL nan_clear_result got=%h exp=3ff0000000000000", d_out); end
    endtask

    task automatic test_busy_ignore();
        int cyc = 1;
        @(negedge clk);
        f_in  = 32'h00000001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!done && cyc < 40) begin
            if (cyc == 5) begin
                f_in  = 32'h3F800000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        checks++; if (cyc != 25) begin errors++; $display("FAIL ignore_latency got=%0d exp=25", cyc); end
        checks++; if (d_out !== 64'h36A0000000000000) begin errors++; $display("FAIL ignore_result got=%h exp=36a0000000000000", d_out); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        logic        nan;
        int          cyc, bcyc;
        bit          to;
        do_conv(32'h3F800000, d, nan, cyc, bcyc, to);
        f_in  = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept done=%b busy=%b exp done=0 busy=1", done, busy); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", done); end
        checks++; if (d_out !== 64'h4000000000000000) begin errors++; $display("FAIL b2b_result got=%h exp=4000000000000000", d_out); end
    endtask

    task automatic test_reset_abort();
        int          saw_done = 0;
        logic [63:0] d;
        logic        nan;
        int          cyc, bcyc;
        bit          to;
        @(negedge clk);
        f_in  = 32'h00000001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL abort_double got=%h exp=0", d_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done++;
        end
        checks++; if (saw_done != 0) begin errors++; $display("FAIL abort_no_done got=%0d pulses exp=0", saw_done); end
        do_conv(32'h3F800000, d, nan, cyc, bcyc, to);
        checks++; if (d !== 64'h3FF0000000000000 || cyc != 2) begin errors++; $display("FAIL abort_recover got=%h lat=%0d exp=3ff0000000000000 lat=2", d, cyc); end
    endtask

    task automatic test_random();
        logic [31:0] f;
        logic [63:0] d, dm;
        logic        nan, nm;
        int          cyc, bcyc, lm;
        bit          to;
        for (int i = 0; i < 150; i++) begin
            f = $urandom;
            case ($urandom_range(0, 3))
                0: f[30:23] = 8'd0;
                1: f[30:23] = 8'hFF;
                2: begin f[30:23] = 8'd0; f[22:0] = 23'(1) << $urandom_range(0, 22); end
                default: ;
            endcase
            model(f, dm, nm, lm);
            do_conv(f, d, nan, cyc, bcyc, to);
            checks++;
            if (to || d !== dm || nan !== nm || cyc != lm) begin
                errors++;
                $display("FAIL rand in=%h got=%h nan=%b lat=%0d exp=%h nan=%b lat=%0d",
                         f, d, nan, cyc, dm, nm, lm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_nan_clear();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
